// File: rtl/periph_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// periph_bus_arbiter_if : requester-side and peripheral-side signal bundle
// Rev 1.0
// ============================================================================
interface periph_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic              m0_req;
    logic              m0_wr;
    logic [MASK_W-1:0] m0_mask;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_err;

    logic              m1_req;
    logic              m1_wr;
    logic [MASK_W-1:0] m1_mask;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_err;

    logic              s_req;
    logic              s_wr;
    logic [MASK_W-1:0] s_mask;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic              s_ack;
    logic [DATA_W-1:0] s_rdata;

    // Arbiter as the target of both requesters
    modport slave (
        input  m0_req, m0_wr, m0_mask, m0_addr, m0_wdata,
        input  m1_req, m1_wr, m1_mask, m1_addr, m1_wdata,
        output m0_ack, m0_rdata, m0_err,
        output m1_ack, m1_rdata, m1_err
    );

    // Arbiter as the single initiator toward the peripheral
    modport master (
        output s_req, s_wr, s_mask, s_addr, s_wdata,
        input  s_ack, s_rdata
    );
endinterface

`default_nettype wire

// File: rtl/periph_bus_arbiter.sv
`default_nettype none
// ============================================================================
// periph_bus_arbiter : two-master round-robin arbiter for one peripheral port.
// Optional watchdog via `define PERIPH_ARB_TIMEOUT_EN.         Rev 1.0
// ============================================================================
module periph_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input wire                   clk,
    input wire                   rst_n,
    periph_bus_arbiter_if.slave  req_bus,
    periph_bus_arbiter_if.master per_bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_check
        $error("periph_bus_arbiter: TIMEOUT_CYCLES must be >= 1");
    end

    state_t            state_q,      state_d;
    logic              grant_id_q,   grant_id_d;
    logic              last_grant_q, last_grant_d;
    logic              s_wr_q,       s_wr_d;
    logic [MASK_W-1:0] s_mask_q,     s_mask_d;
    logic [ADDR_W-1:0] s_addr_q,     s_addr_d;
    logic [DATA_W-1:0] s_wdata_q,    s_wdata_d;
    logic [DATA_W-1:0] rdata_q,      rdata_d;

`ifdef PERIPH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              err_q,        err_d;
`endif

    logic any_req;
    logic winner;
    logic ack0;
    logic ack1;

    // Under contention the master not granted last wins; a lone request wins outright
    always_comb begin
        any_req = req_bus.m0_req | req_bus.m1_req;
        if (req_bus.m0_req && req_bus.m1_req) begin
            winner = ~last_grant_q;
        end else begin
            winner = req_bus.m1_req;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        s_wr_d       = s_wr_q;
        s_mask_d     = s_mask_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        rdata_d      = rdata_q;
`ifdef PERIPH_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d      = ST_BUSY;
                    grant_id_d   = winner;
                    last_grant_d = winner;
                    if (winner) begin
                        s_wr_d    = req_bus.m1_wr;
                        s_mask_d  = req_bus.m1_mask;
                        s_addr_d  = req_bus.m1_addr;
                        s_wdata_d = req_bus.m1_wdata;
                    end else begin
                        s_wr_d    = req_bus.m0_wr;
                        s_mask_d  = req_bus.m0_mask;
                        s_addr_d  = req_bus.m0_addr;
                        s_wdata_d = req_bus.m0_wdata;
                    end
`ifdef PERIPH_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (per_bus.s_ack) begin
                    state_d = ST_DONE;
                    rdata_d = per_bus.s_rdata;
`ifdef PERIPH_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
`ifdef PERIPH_ARB_TIMEOUT_EN
                else begin
                    // A late s_ack on the final cycle is caught by the branch above
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_d = ST_DONE;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            s_wr_q       <= 1'b0;
            s_mask_q     <= '0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            rdata_q      <= '0;
`ifdef PERIPH_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            s_wr_q       <= s_wr_d;
            s_mask_q     <= s_mask_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            rdata_q      <= rdata_d;
`ifdef PERIPH_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign ack0 = (state_q == ST_DONE) && !grant_id_q;
    assign ack1 = (state_q == ST_DONE) &&  grant_id_q;

    assign per_bus.s_req   = (state_q == ST_BUSY);
    assign per_bus.s_wr    = s_wr_q;
    assign per_bus.s_mask  = s_mask_q;
    assign per_bus.s_addr  = s_addr_q;
    assign per_bus.s_wdata = s_wdata_q;

    assign req_bus.m0_ack   = ack0;
    assign req_bus.m1_ack   = ack1;
    assign req_bus.m0_rdata = ack0 ? rdata_q : '0;
    assign req_bus.m1_rdata = ack1 ? rdata_q : '0;

`ifdef PERIPH_ARB_TIMEOUT_EN
    assign req_bus.m0_err = ack0 & err_q;
    assign req_bus.m1_err = ack1 & err_q;
`else
    assign req_bus.m0_err = 1'b0;
    assign req_bus.m1_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/periph_bus_arbiter.md
# periph_bus_arbiter

Two-master arbiter sharing a single peripheral slave port (GPIO, UART, timer bank) between the core data bus and the debug/DMA requester. It sits between the dbus interconnect address decoder and the peripheral. It latches one requester's transaction, drives it to the slave until acknowledge, returns the response, and alternates grants round-robin under contention. An optional watchdog terminates transactions the slave never acknowledges.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 16, maximum BUSY cycles before forced termination (used only with the macro); must be ≥ 1
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- mX_req  in  1  requester X (X = 0 core, 1 debug) transaction request; held high until mX_ack
- mX_wr  in  1  1 = write, 0 = read
- mX_mask  in  DATA_W/8  byte enables
- mX_addr  in  ADDR_W  address
- mX_wdata  in  DATA_W  write data
- mX_ack  out  1  one-cycle completion pulse
- mX_rdata  out  DATA_W  read data, valid while mX_ack = 1
- mX_err  out  1  error flag, valid while mX_ack = 1
- s_req  out  1  slave request
- s_wr, s_mask, s_addr, s_wdata  out  widths as above  latched transaction fields
- s_ack  in  1  slave completion
- s_rdata  in  DATA_W  slave read data, sampled when s_ack = 1

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - If any mX_req = 1: pick the winner, latch its wr/mask/addr/wdata into the s_* registers, record grant_id, go to BUSY.
  - If no request: remain in IDLE.
- Arbitration:
  - A single request wins outright.
  - When both requests are high, the winner is the master not granted last (last_grant register).
  - last_grant resets to 1, so m0 wins the first contention.
  - last_grant updates on every grant.
- BUSY:
  - s_req = 1; s_* fields remain stable.
  - On s_ack = 1: capture s_rdata into the response register, set err = 0, go to DONE.
- DONE:
  - s_req = 0.
  - Assert m[grant_id]_ack = 1 with the registered rdata/err; the other master's ack stays 0.
  - Always go to IDLE next cycle.
- Requester rule: mX_req must deassert in the cycle after mX_ack. IDLE ignores requests only during DONE, so no re-grant occurs on a stale req.
- mX_rdata is driven to 0 whenever mX_ack = 0.
- s_ack is ignored in IDLE and DONE (stray acknowledges produce no effect).
- Input changes on either master while BUSY do not affect the latched transaction.

## Timing
- Reset values: s_req = 0, s_wr = 0, s_mask = 0, s_addr = 0, s_wdata = 0, m0_ack = m1_ack = 0, mX_rdata = 0, mX_err = 0, last_grant = 1, timeout counter = 0.
- Reset applied in any state returns to IDLE on the next edge. The aborted transaction produces no ack.
- Latency:
  - req sampled high in IDLE at edge N.
  - s_req high from cycle N+1.
  - s_ack sampled at edge N+k (k ≥ 1).
  - mX_ack high for cycle N+k+1.
  - IDLE at N+k+2.
- Minimum transaction time (zero-wait slave, s_ack in the first BUSY cycle) is 3 cycles, request to next grant opportunity.
- Back-to-back contention alternates grants with one IDLE cycle between transactions.

## Configuration
- Macro: PERIPH_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments every BUSY cycle without s_ack.
  - When the counter reaches TIMEOUT_CYCLES with s_ack still 0: go to DONE with err = 1, rdata = 0, s_req dropped.
  - The counter clears on entering BUSY.
  - s_ack in the same cycle the count reaches TIMEOUT_CYCLES takes priority: normal completion, err = 0.
- Undefined: BUSY waits indefinitely, mX_err is tied to 0, and no counter is synthesised.

## Test plan
- m0 write addr 0x0000_0004, wdata 0x0000_00A5, mask 0xF, slave acks 2 cycles after s_req -> s_* fields equal the inputs while BUSY; m0_ack pulses exactly once with m0_err = 0; m1_ack stays 0.
- m1 read, slave returns s_rdata 0x0000_003C with zero wait -> m1_ack at N+2 with m1_rdata = 0x3C; rdata = 0 in all other cycles.
- m0 and m1 both request continuously for 4 transactions -> grants m0, m1, m0, m1, with one IDLE cycle between each.
- Timeout (macro on, TIMEOUT_CYCLES = 16), slave never acks -> s_req drops after 16 BUSY cycles; requester gets ack with err = 1, rdata = 0. Repeat with s_ack on the 16th cycle -> err = 0.
- rst_n low for 1 cycle mid-BUSY -> all outputs return to reset values, no ack issued. A subsequent contention is granted to m0.
- s_ack pulsed while IDLE, then m0 read -> no spurious ack, and the m0 read completes normally.
